// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared types and constants for the ST7735 SPI write path
package lcd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    localparam int DC_BIT = 8;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_GAP_CYCLES = 3;

endpackage

// File: rtl/lcd_spi_tick_gen.sv
// rtl/lcd_spi_tick_gen.sv - sclk half-period divider, held at zero while clear is high
module lcd_spi_tick_gen
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = !clear && (div_cnt == LAST);

endmodule

// File: rtl/lcd_spi_writer.sv
// rtl/lcd_spi_writer.sv - SPI mode-0 byte writer for the ST7735 LCD, {dc, byte} words
module lcd_spi_writer
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] data_in,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

    localparam int GW = $clog2(GAP_CYCLES) + 1;

    spi_state_t      state, state_nxt;
    logic [7:0]      shift_q;
    logic            dc_q;
    logic [3:0]      half_q;
    logic [GW-1:0]   gap_q;
    logic            tick;
    logic            tick_clr;
    logic            cs_n_nxt, dc_nxt, sclk_nxt, mosi_nxt, done_nxt, busy_nxt;

    // Divider phase restarts at SETUP entry so SETUP and every half-period are exactly CLK_DIV long.
    assign tick_clr = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_GAP);

    lcd_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (tick_clr),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en_write) state_nxt = ST_SETUP;
            ST_SETUP: if (tick) state_nxt = ST_SHIFT;
            ST_SHIFT: if (tick && (half_q == 4'd15)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_GAP;
            ST_GAP:   if (gap_q == GW'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Shift on the tick that ends an sclk-high half, so mosi moves with the falling edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shift_q <= '0;
            dc_q    <= 1'b0;
            half_q  <= '0;
            gap_q   <= '0;
        end else begin
            gap_q <= (state == ST_GAP) ? gap_q + 1'b1 : '0;
            if (state == ST_IDLE) begin
                half_q <= '0;
                if (en_write) begin
                    shift_q <= data_in[7:0];
                    dc_q    <= data_in[DC_BIT];
                end
            end else if ((state == ST_SHIFT) && tick) begin
                half_q <= half_q + 4'd1;
                if (!half_q[0]) shift_q <= {shift_q[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        cs_n_nxt = 1'b1;
        dc_nxt   = lcd_dc;
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        done_nxt = 1'b0;
        busy_nxt = (state != ST_IDLE);
        case (state)
            ST_SETUP: begin
                cs_n_nxt = 1'b0;
                dc_nxt   = dc_q;
                mosi_nxt = shift_q[7];
            end
            ST_SHIFT: begin
                cs_n_nxt = 1'b0;
                dc_nxt   = dc_q;
                mosi_nxt = shift_q[7];
                sclk_nxt = !half_q[0];
            end
            ST_DONE: begin
                cs_n_nxt = 1'b0;
                dc_nxt   = dc_q;
                mosi_nxt = shift_q[7];
                done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lcd_cs_n <= 1'b1;
            lcd_dc   <= 1'b0;
            lcd_sclk <= 1'b0;
            lcd_mosi <= 1'b0;
            wr_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            lcd_cs_n <= cs_n_nxt;
            lcd_dc   <= dc_nxt;
            lcd_sclk <= sclk_nxt;
            lcd_mosi <= mosi_nxt;
            wr_done  <= done_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule
